// File: rtl/fifo_pkg.sv
// Shared defaults and status type for the DPRAM-backed FIFO controller and
// its checkers.
package fifo_pkg;

  localparam int FIFO_DATA_W = 8;
  localparam int FIFO_ADDR_W = 6;
  localparam int FIFO_DEPTH  = 2 ** FIFO_ADDR_W;
  localparam int FIFO_AF_TH  = 60;
  localparam int FIFO_AE_TH  = 4;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;

endpackage

// File: rtl/fifo_flags.sv
// Pure combinational decode of a FIFO occupancy count into the four status
// flags; usable by any FIFO that keeps an explicit count.
module fifo_flags
  import fifo_pkg::*;
#(
  parameter int CNT_W = FIFO_ADDR_W + 1,
  parameter int DEPTH = FIFO_DEPTH,
  parameter int AF_TH = FIFO_AF_TH,
  parameter int AE_TH = FIFO_AE_TH
) (
  input  logic [CNT_W-1:0] count,
  output fifo_status_t     status
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_TH);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_TH);

  always_comb begin
    status.full         = (count == DEPTH_C);
    status.empty        = (count == '0);
    status.almost_full  = (count >= AF_C);
    status.almost_empty = (count <= AE_C);
  end

endmodule

// File: rtl/fifo_dpram_ctrl.sv
// FIFO controller driving both ports of an external single-clock true DPRAM
// (port A writes, port B reads). Define FIFO_ERR_EN for the sticky error port.
module fifo_dpram_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int ADDR_W = FIFO_ADDR_W,
  parameter int AF_TH  = FIFO_AF_TH,
  parameter int AE_TH  = FIFO_AE_TH
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              push,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pop,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] mem_addr_a,
  output logic [DATA_W-1:0] mem_data_a,
  output logic              mem_we_a,
  output logic [ADDR_W-1:0] mem_addr_b,
  output logic [DATA_W-1:0] mem_data_b,
  output logic              mem_we_b,
  input  logic [DATA_W-1:0] mem_q_b
`ifdef FIFO_ERR_EN
  ,
  output logic              error
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              rd_pend_q, rd_pend_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              push_ok, pop_ok;
  fifo_status_t      status;

  fifo_flags #(
    .CNT_W(ADDR_W + 1),
    .DEPTH(DEPTH),
    .AF_TH(AF_TH),
    .AE_TH(AE_TH)
  ) u_flags (
    .count (count_q),
    .status(status)
  );

  // Requests are qualified by reset_L so the RAM sees no write while reset is held.
  always_comb begin
    push_ok = push && !status.full && reset_L;
    pop_ok  = pop && !status.empty && reset_L;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_pend_d  = pop_ok;
    valid_d    = rd_pend_q;
    data_out_d = data_out_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // RAM output is valid the cycle after the pop; capture it one edge later.
    if (rd_pend_q) data_out_d = mem_q_b;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_pend_q  <= 1'b0;
      valid_q    <= 1'b0;
      data_out_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_pend_q  <= rd_pend_d;
      valid_q    <= valid_d;
      data_out_q <= data_out_d;
    end
  end

`ifdef FIFO_ERR_EN
  logic error_q, error_d;

  always_comb begin
    error_d = error_q | (push && status.full) | (pop && status.empty);
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) error_q <= 1'b0;
    else          error_q <= error_d;
  end

  assign error = error_q;
`endif

  always_comb begin
    mem_we_a     = push_ok;
    mem_addr_a   = wr_ptr_q;
    mem_data_a   = data_in;
    mem_addr_b   = rd_ptr_q;
    mem_data_b   = '0;
    mem_we_b     = 1'b0;
    data_out     = data_out_q;
    valid_out    = valid_q;
    count        = count_q;
    full         = status.full;
    empty        = status.empty;
    almost_full  = status.almost_full;
    almost_empty = status.almost_empty;
  end

endmodule

// File: tb/tb_fifo_dpram_ctrl.sv
// Scoreboard bench for fifo_dpram_ctrl with a behavioural 1-cycle-read DPRAM
// beside it; popped words are matched against a queue of accepted pushes.
module tb_fifo_dpram_ctrl;
  import fifo_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 6;
  localparam int DEPTH = 64;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } rd_t;

  logic          clk = 1'b0;
  logic          reset_L = 1'b1;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          full, empty, almost_full, almost_empty;
  logic [AW:0]   count;
  logic [AW-1:0] mem_addr_a, mem_addr_b;
  logic [DW-1:0] mem_data_a, mem_data_b, mem_q_b;
  logic          mem_we_a, mem_we_b;
`ifdef FIFO_ERR_EN
  logic          error;
`endif

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] sb[$];
  rd_t           rd_exp[$];
  int            mcount = 0;
  int            cyc = 0;
  int            passes = 0;
  int            total = 0;
  bit            in_reset = 1'b0;
  fifo_status_t  dut_st;

  assign dut_st = {full, empty, almost_full, almost_empty};

  fifo_dpram_ctrl dut (
    .clk         (clk),
    .reset_L     (reset_L),
    .push        (push),
    .data_in     (data_in),
    .pop         (pop),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .mem_addr_a  (mem_addr_a),
    .mem_data_a  (mem_data_a),
    .mem_we_a    (mem_we_a),
    .mem_addr_b  (mem_addr_b),
    .mem_data_b  (mem_data_b),
    .mem_we_b    (mem_we_b),
    .mem_q_b     (mem_q_b)
`ifdef FIFO_ERR_EN
    ,
    .error       (error)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_we_a) mem[mem_addr_a] <= mem_data_a;
    if (mem_we_b) mem[mem_addr_b] <= mem_data_b;
    mem_q_b <= mem[mem_addr_b];
  end

  // Scoreboard: every valid_out must match the oldest outstanding pop, on time.
  always @(negedge clk) begin
    if (!in_reset) begin
      if (valid_out === 1'b1) begin
        total++;
        if (rd_exp.size() == 0) begin
          $display("[TB] FAIL unexpected_valid data_out=%h expected no output", data_out);
        end else begin
          rd_t e;
          e = rd_exp.pop_front();
          if (data_out !== e.data || e.due != cyc)
            $display("[TB] FAIL pop_data got=%h@%0d expected=%h@%0d", data_out, cyc, e.data, e.due);
          else
            passes++;
        end
      end else if (rd_exp.size() > 0 && rd_exp[0].due < cyc) begin
        rd_t e;
        total++;
        e = rd_exp.pop_front();
        $display("[TB] FAIL missing_valid valid_out=%b expected data=%h at cycle %0d", valid_out, e.data, e.due);
      end
    end
  end

  function automatic fifo_status_t exp_st(input int c);
    fifo_status_t s;
    s.full         = (c == DEPTH);
    s.empty        = (c == 0);
    s.almost_full  = (c >= 60);
    s.almost_empty = (c <= 4);
    return s;
  endfunction

  task automatic drive(input logic p, input logic [DW-1:0] d, input logic q);
    bit  acc_push, acc_pop;
    rd_t e;
    push = p;
    data_in = d;
    pop = q;
    acc_push = p && (mcount < DEPTH);
    acc_pop  = q && (mcount > 0);
    @(posedge clk);
    #1;
    if (acc_pop) begin
      e.data = sb.pop_front();
      e.due  = cyc + 1;
      rd_exp.push_back(e);
    end
    if (acc_push) sb.push_back(d);
    mcount = mcount + int'(acc_push) - int'(acc_pop);
    push = 1'b0;
    pop = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    in_reset = 1'b1;
    sb.delete();
    rd_exp.delete();
    mcount = 0;
    push = 1'b0;
    pop = 1'b0;
    reset_L = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_L = 1'b1;
    in_reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    in_reset = 1'b1;
    reset_L = 1'b0;
    #1;
    total++; if (count !== 7'd0) $display("[TB] FAIL reset_count got=%0d expected=0", count); else passes++;
    total++; if (dut_st !== exp_st(0)) $display("[TB] FAIL reset_flags got=%b expected=%b", dut_st, exp_st(0)); else passes++;
    total++; if (valid_out !== 1'b0) $display("[TB] FAIL reset_valid got=%b expected=0", valid_out); else passes++;
    total++; if (mem_we_a !== 1'b0) $display("[TB] FAIL reset_we_a got=%b expected=0", mem_we_a); else passes++;
    do_reset();
    idle(2);
    total++; if (count !== 7'd0) $display("[TB] FAIL idle_count got=%0d expected=0", count); else passes++;
    total++; if (dut_st !== exp_st(0)) $display("[TB] FAIL idle_flags got=%b expected=%b", dut_st, exp_st(0)); else passes++;
    total++; if (valid_out !== 1'b0 || mem_we_a !== 1'b0)
      $display("[TB] FAIL idle_outputs got valid=%b we=%b expected 0 0", valid_out, mem_we_a); else passes++;
  endtask

  task automatic test_fill_wrap();
    for (int i = 0; i < DEPTH; i++) begin
      logic [DW-1:0] v;
      v = DW'(i);
      drive(1'b1, v, 1'b0);
      total++; if (count !== 7'(mcount)) $display("[TB] FAIL fill_count got=%0d expected=%0d", count, mcount); else passes++;
      total++; if (dut_st !== exp_st(mcount))
        $display("[TB] FAIL fill_flags at %0d got=%b expected=%b", mcount, dut_st, exp_st(mcount)); else passes++;
    end
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, '0, 1'b1);
      total++; if (dut_st !== exp_st(mcount))
        $display("[TB] FAIL drain_flags at %0d got=%b expected=%b", mcount, dut_st, exp_st(mcount)); else passes++;
    end
    idle(3);
    total++; if (rd_exp.size() != 0) $display("[TB] FAIL fill_drain_pending got=%0d expected=0", rd_exp.size()); else passes++;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH; i++) drive(1'b1, DW'($urandom_range(0, 255)), 1'b0);
    drive(1'b1, 8'hAA, 1'b0);
    total++; if (count !== 7'd64) $display("[TB] FAIL overflow_count got=%0d expected=64", count); else passes++;
    total++; if (full !== 1'b1) $display("[TB] FAIL overflow_full got=%b expected=1", full); else passes++;
`ifdef FIFO_ERR_EN
    total++; if (error !== 1'b1) $display("[TB] FAIL overflow_error got=%b expected=1", error); else passes++;
`endif
    for (int i = 0; i < DEPTH; i++) drive(1'b0, '0, 1'b1);
    idle(3);
    drive(1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, 1'b0);
      total++; if (valid_out !== 1'b0) $display("[TB] FAIL underflow_valid got=%b expected=0", valid_out); else passes++;
    end
    total++; if (count !== 7'd0) $display("[TB] FAIL underflow_count got=%0d expected=0", count); else passes++;
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 0; i < 10; i++) drive(1'b1, 8'h10 + DW'(i), 1'b0);
    drive(1'b1, 8'h77, 1'b1);
    total++; if (count !== 7'd10) $display("[TB] FAIL simul10_count got=%0d expected=10", count); else passes++;
    for (int i = 0; i < 10; i++) drive(1'b0, '0, 1'b1);
    idle(3);
    drive(1'b1, 8'h99, 1'b1);
    total++; if (count !== 7'd1) $display("[TB] FAIL simul0_count got=%0d expected=1", count); else passes++;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, '0, 1'b0);
      total++; if (valid_out !== 1'b0) $display("[TB] FAIL simul0_valid got=%b expected=0", valid_out); else passes++;
    end
    for (int i = 0; i < DEPTH - 1; i++) drive(1'b1, DW'($urandom_range(0, 255)), 1'b0);
    drive(1'b1, 8'hEE, 1'b1);
    total++; if (count !== 7'd63) $display("[TB] FAIL simul64_count got=%0d expected=63", count); else passes++;
    for (int i = 0; i < DEPTH - 1; i++) drive(1'b0, '0, 1'b1);
    idle(3);
    total++; if (rd_exp.size() != 0) $display("[TB] FAIL simul_pending got=%0d expected=0", rd_exp.size()); else passes++;
  endtask

  task automatic test_wrap_stream();
    int bad;
    do_reset();
    bad = 0;
    for (int i = 0; i < 3; i++) drive(1'b1, DW'($urandom_range(0, 255)), 1'b0);
    for (int i = 0; i < 200; i++) begin
      drive(1'b1, DW'($urandom_range(0, 255)), 1'b1);
      if (count !== 7'd3) bad++;
    end
    total++; if (bad != 0) $display("[TB] FAIL stream_count cycles_off=%0d expected=0", bad); else passes++;
    for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b1);
    idle(3);
    total++; if (rd_exp.size() != 0) $display("[TB] FAIL stream_pending got=%0d expected=0", rd_exp.size()); else passes++;
    total++; if (empty !== 1'b1) $display("[TB] FAIL stream_empty got=%b expected=1", empty); else passes++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 20; i++) drive(1'b1, 8'h80 + DW'(i), 1'b0);
    drive(1'b0, '0, 1'b1);
    in_reset = 1'b1;
    sb.delete();
    rd_exp.delete();
    mcount = 0;
    #2;
    reset_L = 1'b0;
    #1;
    total++; if (count !== 7'd0) $display("[TB] FAIL midreset_count got=%0d expected=0", count); else passes++;
    total++; if (dut_st !== exp_st(0)) $display("[TB] FAIL midreset_flags got=%b expected=%b", dut_st, exp_st(0)); else passes++;
    total++; if (valid_out !== 1'b0 || data_out !== 8'h00)
      $display("[TB] FAIL midreset_out got valid=%b data=%h expected 0 00", valid_out, data_out); else passes++;
    @(posedge clk);
    @(negedge clk);
    reset_L = 1'b1;
    in_reset = 1'b0;
    @(posedge clk);
    #1;
    drive(1'b1, 8'h5A, 1'b0);
    drive(1'b1, 8'hC3, 1'b0);
    total++; if (count !== 7'd2) $display("[TB] FAIL midreset_refill got=%0d expected=2", count); else passes++;
    drive(1'b0, '0, 1'b1);
    drive(1'b0, '0, 1'b1);
    idle(3);
    total++; if (rd_exp.size() != 0) $display("[TB] FAIL midreset_pending got=%0d expected=0", rd_exp.size()); else passes++;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_fill_wrap();
    test_overflow();
    test_simultaneous();
    test_wrap_stream();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
